// File: rtl/conv_encoder_punct_if.sv
// Bit-stream interface between the scrambler, the K=7 convolutional encoder and the interleaver.
// master drives the scrambled bit stream; slave is the encoder side.
interface conv_encoder_punct_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       frame_start;
    logic       in_last;
    logic [3:0] rate;
    logic [1:0] coded_bits;
    logic [1:0] coded_valid;
    logic       out_last;
    logic       rate_err;

    modport master (
        output in_valid, in_bit, frame_start, in_last, rate,
        input  in_ready, coded_bits, coded_valid, out_last, rate_err
    );

    modport slave (
        input  in_valid, in_bit, frame_start, in_last, rate,
        output in_ready, coded_bits, coded_valid, out_last, rate_err
    );
endinterface

// File: rtl/conv_encoder_punct.sv
// 802.11a K=7 convolutional encoder (g0=133 -> A, g1=171 -> B) with rate 1/2, 2/3, 3/4 puncturing.
// Optional CONV_FLUSH_EN: encoder appends TAIL_BITS zero bits itself after the in_last bit.
module conv_encoder_punct #(
    parameter int unsigned K = 7
`ifdef CONV_FLUSH_EN
    ,
    parameter int unsigned TAIL_BITS = 6
`endif
) (
    input logic                Clk,
    input logic                Reset,
    conv_encoder_punct_if.slave bus
);

    localparam int unsigned SrW = K - 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun
`ifdef CONV_FLUSH_EN
        ,
        StFlush
`endif
    } state_e;

    typedef enum logic [1:0] {
        Rate12,
        Rate23,
        Rate34
    } rate_e;

    state_e         state_q;
    rate_e          rate_q;
    rate_e          new_rate;
    rate_e          cur_rate;
    logic           new_err;
    logic [SrW-1:0] sr_q;
    logic [SrW-1:0] cur_sr;
    logic [1:0]     cnt_q;
    logic [1:0]     cur_cnt;
    logic [1:0]     cnt_nxt;
    logic [1:0]     mask;
    logic           accept;
    logic           start;
    logic           frame_bit;
    logic           flush_step;
    logic           enc_step;
    logic           enc_bit;
    logic           last_in;
    logic           enc_a;
    logic           enc_b;
    logic [1:0]     coded_bits_q;
    logic [1:0]     coded_valid_q;
    logic           out_last_q;
    logic           rate_err_q;

`ifdef CONV_FLUSH_EN
    localparam int unsigned FcW = $clog2(TAIL_BITS);
    logic [FcW-1:0] flush_cnt_q;

    assign bus.in_ready = (state_q != StFlush);
`else
    assign bus.in_ready = 1'b1;
`endif

    assign bus.coded_bits  = coded_bits_q;
    assign bus.coded_valid = coded_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.rate_err    = rate_err_q;

    always_comb begin
        new_rate = Rate12;
        new_err  = 1'b0;
        case (bus.rate)
            4'b1101, 4'b0101, 4'b1001:          new_rate = Rate12;
            4'b0001:                            new_rate = Rate23;
            4'b1111, 4'b0111, 4'b1011, 4'b0011: new_rate = Rate34;
            default: begin
                new_rate = Rate12;
                new_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        accept     = bus.in_valid & bus.in_ready;
        start      = accept & bus.frame_start;
        frame_bit  = 1'b0;
        flush_step = 1'b0;
        case (state_q)
            StIdle:  frame_bit = start;
            StRun:   frame_bit = accept;
`ifdef CONV_FLUSH_EN
            StFlush: flush_step = 1'b1;
`endif
            default: frame_bit = 1'b0;
        endcase
        enc_step = frame_bit | flush_step;
        // Flush steps inject zeros, so only real frame bits reach the encoder input.
        enc_bit  = frame_bit & bus.in_bit;
        last_in  = frame_bit & bus.in_last;

        cur_sr   = start ? '0 : sr_q;
        cur_cnt  = start ? 2'd0 : cnt_q;
        cur_rate = start ? new_rate : rate_q;

        // cur_sr[i] holds the bit encoded i+1 steps ago.
        enc_a = enc_bit ^ cur_sr[1] ^ cur_sr[2] ^ cur_sr[4] ^ cur_sr[5];
        enc_b = enc_bit ^ cur_sr[0] ^ cur_sr[1] ^ cur_sr[2] ^ cur_sr[5];

        mask    = 2'b11;
        cnt_nxt = 2'd0;
        case (cur_rate)
            Rate23: begin
                mask    = (cur_cnt == 2'd0) ? 2'b11 : 2'b10;
                cnt_nxt = (cur_cnt == 2'd1) ? 2'd0 : cur_cnt + 2'd1;
            end
            Rate34: begin
                case (cur_cnt)
                    2'd0:    mask = 2'b11;
                    2'd1:    mask = 2'b10;
                    default: mask = 2'b01;
                endcase
                cnt_nxt = (cur_cnt == 2'd2) ? 2'd0 : cur_cnt + 2'd1;
            end
            default: begin
                mask    = 2'b11;
                cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            rate_q        <= Rate12;
            sr_q          <= '0;
            cnt_q         <= 2'd0;
            coded_bits_q  <= 2'b00;
            coded_valid_q <= 2'b00;
            out_last_q    <= 1'b0;
            rate_err_q    <= 1'b0;
`ifdef CONV_FLUSH_EN
            flush_cnt_q   <= '0;
`endif
        end else begin
            coded_bits_q  <= 2'b00;
            coded_valid_q <= 2'b00;
            out_last_q    <= 1'b0;

            if (enc_step) begin
                sr_q          <= {cur_sr[SrW-2:0], enc_bit};
                cnt_q         <= cnt_nxt;
                coded_bits_q  <= {enc_a, enc_b};
                coded_valid_q <= mask;
            end

            if (start) begin
                rate_q     <= new_rate;
                rate_err_q <= new_err;
            end

            if (frame_bit) begin
                state_q <= StRun;
            end

            if (last_in) begin
`ifdef CONV_FLUSH_EN
                state_q     <= StFlush;
                flush_cnt_q <= '0;
`else
                state_q     <= StIdle;
                out_last_q  <= 1'b1;
`endif
            end

`ifdef CONV_FLUSH_EN
            if (flush_step) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
                if (flush_cnt_q == FcW'(TAIL_BITS - 1)) begin
                    out_last_q <= 1'b1;
                    state_q    <= StIdle;
                end
            end
`endif
        end
    end

endmodule
